// File: rtl/data_mem_ws.sv
// ---------------------------------------------------------------------------
// data_mem_ws
//   Word-organised data memory for the load/store path with a configurable
//   number of wait states. One request is in flight at a time: a request is
//   taken over a valid/ready channel, held for LATENCY cycles, performed, and
//   the response is presented on a valid/ready channel until the consumer
//   accepts it. Misaligned, illegal-size and out-of-range requests are
//   answered with resp_err=1 and never touch the array.
//
// Parameters
//   ADDR_WIDTH  byte-address width; word index = req_addr[ADDR_WIDTH-1:2]
//   MEM_DEPTH   number of 32-bit words (<= 2**(ADDR_WIDTH-2))
//   LATENCY     wait states between accept and access (0..15)
//
// Ports
//   clk, reset        clock (rising edge) / asynchronous active-low reset
//   req_valid/ready   request handshake; req_ready is high only in IDLE
//   req_we            1 = store, 0 = load
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      loads zero-extend when 1, sign-extend when 0
//   resp_valid/ready  response handshake (backpressure supported)
//   resp_rdata        load result, 0 for stores and errors
//   resp_err          request was rejected
// ---------------------------------------------------------------------------
module data_mem_ws #(
   parameter int ADDR_WIDTH = 12,
   parameter int MEM_DEPTH  = 1024,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err
);

   localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   // With no wait states the access happens on the accept edge, so the
   // datapath is fed straight from the request inputs instead of the capture.
   localparam bit ZERO_LAT = (LATENCY == 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              we_q;
   logic [IDX_W+1:0]  addr_q;     // only the in-range part is needed once checked
   logic [31:0]       wdata_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic              resp_valid_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_err_q;

   logic [31:0]       mem_q [MEM_DEPTH];

   // ---------------- request decode ----------------
   logic [31:0] req_idx;
   logic        req_err;

   always_comb begin
      req_idx = 32'(req_addr[ADDR_WIDTH-1:2]);
      req_err = (req_size == 2'b11)
              || ((req_size == 2'b01) && req_addr[0])
              || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
              || (req_idx >= 32'(MEM_DEPTH));
   end

   // ---------------- access datapath ----------------
   logic             acc_we;
   logic [IDX_W-1:0] acc_idx;
   logic [1:0]       acc_lane;
   logic [31:0]      acc_wdata;
   logic [1:0]       acc_size;
   logic             acc_uns;
   logic             acc_go;
   logic             mem_wr;
   logic [3:0]       be;
   logic [31:0]      wd_rep;
   logic [31:0]      rd_word;
   logic [15:0]      rd_sh;
   logic [31:0]      load_data;

   always_comb begin
      acc_we    = ZERO_LAT ? req_we                 : we_q;
      acc_idx   = ZERO_LAT ? req_addr[IDX_W+1:2]    : addr_q[IDX_W+1:2];
      acc_lane  = ZERO_LAT ? req_addr[1:0]          : addr_q[1:0];
      acc_wdata = ZERO_LAT ? req_wdata              : wdata_q;
      acc_size  = ZERO_LAT ? req_size               : size_q;
      acc_uns   = ZERO_LAT ? req_unsigned           : uns_q;
   end

   // The access edge: accept edge when there are no wait states, otherwise
   // the WAIT edge where the counter has run out. Gated by reset so a store
   // can never land while the block is being held in reset.
   always_comb begin
      acc_go = 1'b0;
      if (reset) begin
         if (ZERO_LAT)
            acc_go = (state_q == IDLE) && req_valid && !req_err;
         else
            acc_go = (state_q == WAIT) && (cnt_q == 4'd0);
      end
      mem_wr = acc_go && acc_we;
   end

   // Byte enables and lane-replicated store data.
   always_comb begin
      be     = 4'b0000;
      wd_rep = acc_wdata;
      case (acc_size)
         2'b00: begin
            be     = 4'b0001 << acc_lane;
            wd_rep = {4{acc_wdata[7:0]}};
         end
         2'b01: begin
            be     = acc_lane[1] ? 4'b1100 : 4'b0011;
            wd_rep = {2{acc_wdata[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem_q[acc_idx][8*b +: 8] <= wd_rep[8*b +: 8];
      end
   end

   // Load lane select and extension. Shifting by lane*8 right-aligns the
   // addressed byte/half; only the low 16 bits are ever needed from it.
   always_comb begin
      rd_word = mem_q[acc_idx];
      rd_sh   = 16'(rd_word >> {acc_lane, 3'b000});
      case (acc_size)
         2'b00:   load_data = {{24{~acc_uns & rd_sh[7]}},  rd_sh[7:0]};
         2'b01:   load_data = {{16{~acc_uns & rd_sh[15]}}, rd_sh[15:0]};
         default: load_data = rd_word;
      endcase
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= 32'd0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr[IDX_W+1:0];
                  wdata_q <= req_wdata;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  if (req_err) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'd0;
                  end else if (ZERO_LAT) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b0;
                     resp_rdata_q <= req_we ? 32'd0 : load_data;
                  end else begin
                     cnt_q   <= 4'(LATENCY - 1);
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= we_q ? 32'd0 : load_data;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  resp_rdata_q <= 32'd0;
                  resp_err_q   <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_ws.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ws
//   Two instances: u0 (LATENCY=0, MEM_DEPTH=1024) and u1 (LATENCY=2,
//   MEM_DEPTH=512). The driver pushes the expected response, computed from a
//   byte-addressed reference memory, at the moment a request is accepted; a
//   per-instance monitor pops and compares on every response handshake,
//   including the edge on which the response first appeared.
// ---------------------------------------------------------------------------
module tb_data_mem_ws;

   localparam int AW = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  resp_valid, resp_ready, resp_err;
   logic [AW-1:0] req_addr [2];
   logic [31:0] req_wdata [2];
   logic [31:0] resp_rdata [2];
   logic [1:0]  req_size [2];

   data_mem_ws #(.ADDR_WIDTH(AW), .MEM_DEPTH(1024), .LATENCY(0)) u0 (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
      .req_unsigned(req_unsigned[0]), .resp_valid(resp_valid[0]),
      .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

   data_mem_ws #(.ADDR_WIDTH(AW), .MEM_DEPTH(512), .LATENCY(2)) u1 (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
      .req_unsigned(req_unsigned[1]), .resp_valid(resp_valid[1]),
      .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int d);
      return (d == 0) ? 0 : 2;
   endfunction
   function automatic int depth_of(input int d);
      return (d == 0) ? 1024 : 512;
   endfunction

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          due;
   } exp_t;

   exp_t        sbq [2][$];
   logic [7:0]  mb [2][256];
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: byte-addressed store/load with extension.
   function automatic void model(input int d, input bit we, input logic [AW-1:0] a,
                                 input logic [31:0] wd, input logic [1:0] sz, input bit u,
                                 output logic [31:0] rd, output logic err);
      int n;
      logic [31:0] v;
      err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
            || ((int'(a) / 4) >= depth_of(d));
      rd = 32'd0;
      if (err) return;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if (we) begin
         for (int i = 0; i < n; i++) mb[d][int'(a) + i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(mb[d][int'(a) + i]) << (8*i));
         if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
         rd = v;
      end
   endfunction

   // Response-side backpressure.
   logic [1:0] rr_rand = 2'b00;
   logic [1:0] rr_hold = 2'b00;
   initial resp_ready = 2'b11;
   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++)
         resp_ready[d] = rr_hold[d] ? 1'b0 : rr_rand[d] ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   // Issue one request; returns the accept edge number.
   task automatic do_req(input int d, input bit we, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit u, input bit track, output int acc_edge);
      exp_t e;
      int   t;
      @(negedge clk);
      req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a;
      req_wdata[d] = wd; req_size[d] = sz; req_unsigned[d] = u;
      t = 0;
      while (!req_ready[d] && t < 300) begin
         @(negedge clk);
         t++;
      end
      acc_edge = cyc + 1;
      if (t >= 300) begin
         chk("accept_timeout", 32'(t), 32'd0);
         req_valid[d] = 1'b0;
         return;
      end
      if (track) begin
         model(d, we, a, wd, sz, u, e.rd, e.err);
         e.due = acc_edge + (e.err ? 0 : lat_of(d));
         sbq[d].push_back(e);
      end
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      int t = 0;
      while (sbq[d].size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) chk("drain_timeout", 32'(sbq[d].size()), 32'd0);
   endtask

   task automatic rand_ops(input int d, input int cnt);
      int ae;
      for (int k = 0; k < cnt; k++) begin
         logic [1:0] sz;
         logic [AW-1:0] a;
         int r = $urandom_range(0, 7);
         if (r == 0) begin
            case ($urandom_range(0, 3))
               0: begin sz = 2'd3; a = AW'($urandom_range(0, 63)); end
               1: begin sz = 2'd1; a = AW'($urandom_range(0, 31) * 2 + 1); end
               2: begin sz = 2'd2; a = AW'($urandom_range(0, 15) * 4 + $urandom_range(1, 3)); end
               default: begin
                  if (d == 1) begin sz = 2'd2; a = AW'(12'h800 + $urandom_range(0, 511) * 4); end
                  else        begin sz = 2'd3; a = AW'($urandom_range(0, 63)); end
               end
            endcase
         end else begin
            sz = 2'($urandom_range(0, 2));
            a  = AW'($urandom_range(0, 15) * 4);
            if (sz == 2'd0) a = a + AW'($urandom_range(0, 3));
            if (sz == 2'd1) a = a + AW'($urandom_range(0, 1) * 2);
         end
         do_req(d, 1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)), 1'b1, ae);
      end
   endtask

   // Monitors: one per instance.
   for (genvar g = 0; g < 2; g++) begin : g_mon
      logic        seen = 1'b0;
      int          first = 0;
      logic [31:0] hrd = 32'd0;
      logic        herr = 1'b0;
      exp_t        e;
      int          f;
      always @(negedge clk) begin
         if (!rst_n) begin
            seen <= 1'b0;
         end else if (resp_valid[g]) begin
            chk($sformatf("req_ready_busy%0d", g), 32'(req_ready[g]), 32'd0);
            if (seen) begin
               chk($sformatf("hold_rdata%0d", g), resp_rdata[g], hrd);
               chk($sformatf("hold_err%0d", g), 32'(resp_err[g]), 32'(herr));
            end
            f = seen ? first : cyc;
            if (resp_ready[g]) begin
               if (sbq[g].size() == 0) begin
                  chk($sformatf("unexpected_resp%0d", g), 32'(sbq[g].size()), 32'd1);
               end else begin
                  e = sbq[g].pop_front();
                  chk($sformatf("rdata%0d", g), resp_rdata[g], e.rd);
                  chk($sformatf("err%0d", g), 32'(resp_err[g]), 32'(e.err));
                  chk($sformatf("latency%0d", g), 32'(f), 32'(e.due));
               end
               seen <= 1'b0;
            end else if (!seen) begin
               seen  <= 1'b1;
               first <= cyc;
               hrd   <= resp_rdata[g];
               herr  <= resp_err[g];
            end
         end
      end
   end

   initial begin
      int ae, ae2, la, na;
      req_valid = 2'b00; req_we = 2'b00; req_unsigned = 2'b00;
      for (int d = 0; d < 2; d++) begin
         req_addr[d] = '0; req_wdata[d] = 32'd0; req_size[d] = 2'd0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
         chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
         chk("rst_resp_rdata", resp_rdata[d], 32'd0);
         chk("rst_resp_err", 32'(resp_err[d]), 32'd0);
      end
      rst_n = 1'b1;

      // ---------- LATENCY=2 instance ----------
      for (int w = 0; w < 16; w++) do_req(1, 1'b1, AW'(w*4), $urandom, 2'd2, 1'b0, 1'b1, ae);
      // word store / load
      do_req(1, 1'b1, 12'h010, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, ae);
      do_req(1, 1'b0, 12'h010, 32'd0,        2'd2, 1'b0, 1'b1, ae);
      // byte store then sub-word loads
      do_req(1, 1'b1, 12'h013, 32'h000001A5, 2'd0, 1'b0, 1'b1, ae);
      do_req(1, 1'b0, 12'h010, 32'd0, 2'd2, 1'b0, 1'b1, ae);
      do_req(1, 1'b0, 12'h013, 32'd0, 2'd0, 1'b0, 1'b1, ae);
      do_req(1, 1'b0, 12'h013, 32'd0, 2'd0, 1'b1, 1'b1, ae);
      do_req(1, 1'b0, 12'h012, 32'd0, 2'd1, 1'b0, 1'b1, ae);
      do_req(1, 1'b0, 12'h012, 32'd0, 2'd1, 1'b1, 1'b1, ae);
      // error cases
      do_req(1, 1'b1, 12'h011, 32'h1111, 2'd1, 1'b0, 1'b1, ae);
      do_req(1, 1'b1, 12'h012, 32'h2222, 2'd2, 1'b0, 1'b1, ae);
      do_req(1, 1'b0, 12'h010, 32'd0,    2'd3, 1'b0, 1'b1, ae);
      do_req(1, 1'b0, 12'h800, 32'd0,    2'd2, 1'b0, 1'b1, ae);
      do_req(1, 1'b0, 12'h010, 32'd0,    2'd2, 1'b0, 1'b1, ae);
      drain(1);

      // backpressure: response held, new request must wait
      rr_hold[1] = 1'b1;
      do_req(1, 1'b0, 12'h010, 32'd0, 2'd2, 1'b0, 1'b1, la);
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 12'h014;
      req_wdata[1] = 32'h0000_0055; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("held_req_ready", 32'(req_ready[1]), 32'd0);
      end
      rr_hold[1] = 1'b0;
      do_req(1, 1'b1, 12'h014, 32'h0000_0055, 2'd2, 1'b0, 1'b1, na);
      chk("accept_after_release", 32'(na > la + 7), 32'd1);
      drain(1);

      // reset during WAIT of a store
      do_req(1, 1'b1, 12'h020, 32'hCAFEF00D, 2'd2, 1'b0, 1'b1, ae);
      drain(1);
      do_req(1, 1'b1, 12'h020, 32'h12345678, 2'd2, 1'b0, 1'b0, ae);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_req_ready", 32'(req_ready[1]), 32'd1);
      chk("midrst_resp_valid", 32'(resp_valid[1]), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("postrst_req_ready", 32'(req_ready[1]), 32'd1);
      chk("postrst_resp_valid", 32'(resp_valid[1]), 32'd0);
      do_req(1, 1'b0, 12'h020, 32'd0, 2'd2, 1'b0, 1'b1, ae);
      drain(1);

      rr_rand[1] = 1'b1;
      rand_ops(1, 80);
      drain(1);
      rr_rand[1] = 1'b0;

      // ---------- LATENCY=0 instance ----------
      for (int w = 0; w < 16; w++) do_req(0, 1'b1, AW'(w*4), $urandom, 2'd2, 1'b0, 1'b1, ae);
      drain(0);
      do_req(0, 1'b1, 12'h004, 32'h0BAD_F00D, 2'd2, 1'b0, 1'b1, ae);
      do_req(0, 1'b0, 12'h004, 32'd0,         2'd2, 1'b0, 1'b1, ae2);
      chk("lat0_accept_spacing", 32'(ae2 - ae), 32'd2);
      drain(0);
      rr_rand[0] = 1'b1;
      rand_ops(0, 80);
      drain(0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_ws.md
Name: data_mem_ws

Overview:
- Parametrised word-organised data memory with a configurable wait-state count, for the RISC-V load/store path.
- Accepts one request at a time over a valid/ready request channel and returns one response over a valid/ready response channel with backpressure.
- Supports byte, half-word and word accesses with byte-lane writes and sign/zero-extended loads.
- Flags misaligned and out-of-range accesses instead of performing them.

Parameters:
- ADDR_WIDTH, 12: byte-address width; word index = req_addr[ADDR_WIDTH-1:2].
- MEM_DEPTH, 1024: number of 32-bit words; must satisfy MEM_DEPTH <= 2^(ADDR_WIDTH-2).
- LATENCY, 2: wait states between accept and access, range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high exactly when in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal-size or out-of-range request.

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, wait counter 0, captured request cleared. req_ready reads 1 after reset because it decodes IDLE.
- Memory array is not cleared by reset; contents are undefined until written.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - Accept on edge with req_valid && req_ready.
  - Capture we, addr, wdata, size and unsigned.
  - Compute err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | (word index >= MEM_DEPTH).
  - If err: go to RESP with resp_err=1 and resp_rdata=0; no memory access.
  - Else if LATENCY==0: perform the access on the same accept edge and go to RESP.
  - Else: load counter = LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter != 0, decrement it.
  - If counter == 0, perform the access on that edge and go to RESP.
- Access (store):
  - Byte: write lane addr[1:0] with wdata[7:0].
  - Half: write lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word: write all lanes.
  - Other lanes are unchanged; resp_rdata=0.
- Access (load):
  - Read the word and select the lane(s) by addr[1:0].
  - Extend to 32 bits per req_unsigned; word loads pass through.
  - Result is registered into resp_rdata.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - On edge with resp_ready: clear resp_valid, resp_rdata and resp_err to 0 and go to IDLE.
- Latency:
  - resp_valid rises in the cycle after edge T+LATENCY (T = accept edge), so it is visible L+1 edges after accept.
  - Error responses take 1 edge regardless of LATENCY.
  - Throughput is one request per LATENCY+2 cycles with resp_ready held high.
- Requests presented while req_ready=0 are ignored, not queued. The requester holds them until accepted.
- Reset mid-operation:
  - Aborts immediately and returns to IDLE.
  - A store still in WAIT is never written.
  - A response pending in RESP is discarded.

Test Plan:
1. LATENCY=2: store word 0xDEADBEEF @0x010, then load word @0x010 -> each resp_valid 3 edges after accept; load resp_rdata=0xDEADBEEF, resp_err=0.
2. After 1: store byte 0x1A5 @0x013 -> load word @0x010 = 0xA5ADBEEF; LB @0x013 = 0xFFFFFFA5; LBU @0x013 = 0x000000A5; LH @0x012 = 0xFFFFA5AD; LHU @0x012 = 0x0000A5AD.
3. Store half @0x011, store word @0x012, req_size=11, and (MEM_DEPTH=512) load @0x800 -> each gives resp_err=1 and resp_rdata=0 one edge after accept; word @0x010 still 0xA5ADBEEF.
4. Hold resp_ready=0 for 5 cycles on a load -> resp_valid and data stay stable; req_ready=0; a new req_valid is ignored; the new request is accepted only after resp_ready and the return to IDLE.
5. Assert reset during WAIT of a store 0x12345678 @0x020 that holds 0xCAFEF00D -> after reset, req_ready=1, resp_valid=0, and load @0x020 returns 0xCAFEF00D.
6. LATENCY=0: back-to-back store then load @0x004 with resp_ready=1 -> resp_valid one edge after each accept; accepts 2 cycles apart; load returns the stored value.
